// File: rtl/lfsr_keystream_gen.sv
// LFSR keystream generator.
// A Fibonacci or Galois LFSR with a loadable seed and tap mask. A run produces
// `rounds` keystream bits, one per cycle, presented on bit_out/bit_valid and
// shifted into a packed capture register with the most recent bit at the LSB.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; load and start are accepted only here
// RUN    | one keystream bit presented per cycle, LFSR advances each edge
// DONE   | one-cycle completion pulse, then back to IDLE
module lfsr_keystream_gen #(
    parameter int              WIDTH = 16,
    parameter int              CNT_W = 8,
    parameter int              OUT_W = 32,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] taps_in,
    input  logic             mode,
    input  logic             load,
    input  logic             start,
    input  logic [CNT_W-1:0] rounds,
    output logic             busy,
    output logic             done,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [OUT_W-1:0] bitstream,
    output logic [WIDTH-1:0] state_out,
    output logic             seed_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [WIDTH-1:0] STATE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    fsm_t             r_fsm;
    fsm_t             w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_taps;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic [OUT_W-1:0] r_bitstream;
    logic             r_seed_err;

    logic             w_load_acc;
    logic             w_start_acc;
    logic             w_run;
    logic [WIDTH-1:0] w_fib_next;
    logic [WIDTH-1:0] w_gal_next;
    logic [WIDTH-1:0] w_state_next;

    assign w_load_acc  = (r_fsm == S_IDLE) && load;
    assign w_start_acc = (r_fsm == S_IDLE) && start;
    assign w_run       = (r_fsm == S_RUN);

    assign w_fib_next   = {^(r_state & r_taps), r_state[WIDTH-1:1]};
    assign w_gal_next   = {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? r_taps : '0);
    assign w_state_next = r_mode ? w_gal_next : w_fib_next;

    // Bits are presented straight from the state register so the first bit is
    // visible in the first RUN cycle, and the edge that ends the cycle commits it.
    assign bit_out   = w_run & r_state[0];
    assign bitstream = r_bitstream;
    assign state_out = r_state;
    assign seed_err  = r_seed_err;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        w_fsm_next = r_fsm;
        busy       = 1'b0;
        done       = 1'b0;
        bit_valid  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    w_fsm_next = (rounds == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_fsm_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                w_fsm_next = S_IDLE;
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // LFSR state, taps, round counter and capture register.
    // Load is only accepted in IDLE and RUN advances are only in RUN, so the
    // two never collide; a same-cycle load+start therefore runs from the new seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SEED;
            r_taps      <= TAPS;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_bitstream <= '0;
            r_seed_err  <= 1'b0;
        end else begin
            if (w_load_acc) begin
                r_taps <= taps_in;
                if (seed_in == '0) begin
                    r_state    <= STATE_ONE;
                    r_seed_err <= 1'b1;
                end else begin
                    r_state    <= seed_in;
                    r_seed_err <= 1'b0;
                end
            end
            if (w_start_acc) begin
                r_bitstream <= '0;
                r_cnt       <= rounds;
                r_mode      <= mode;
            end
            if (w_run) begin
                r_state     <= w_state_next;
                r_bitstream <= {r_bitstream[OUT_W-2:0], r_state[0]};
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_keystream_gen.sv
// Directed bench for lfsr_keystream_gen at WIDTH=4, OUT_W=8.
module tb_lfsr_keystream_gen;

    localparam int              WIDTH = 4;
    localparam int              CNT_W = 8;
    localparam int              OUT_W = 8;
    localparam logic [WIDTH-1:0] SEED  = 4'b1011;
    localparam logic [WIDTH-1:0] TAPS  = 4'b1001;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] taps_in;
    logic             mode;
    logic             load;
    logic             start;
    logic [CNT_W-1:0] rounds;
    logic             busy;
    logic             done;
    logic             bit_out;
    logic             bit_valid;
    logic [OUT_W-1:0] bitstream;
    logic [WIDTH-1:0] state_out;
    logic             seed_err;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_keystream_gen #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .OUT_W(OUT_W), .SEED(SEED), .TAPS(TAPS)
    ) dut (
        .clk(clk), .reset(reset), .seed_in(seed_in), .taps_in(taps_in),
        .mode(mode), .load(load), .start(start), .rounds(rounds),
        .busy(busy), .done(done), .bit_out(bit_out), .bit_valid(bit_valid),
        .bitstream(bitstream), .state_out(state_out), .seed_err(seed_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs `n` RUN cycles checking the presented bit against exp_bits (first bit at index 0).
    task automatic run_bits(input string tag, input int n, input logic [15:0] exp_bits);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(bit_valid), 32'd1);
            check({tag, "_bit"},   32'(bit_out),   32'(exp_bits[i]));
            check({tag, "_done"},  32'(done),      32'd0);
            tick();
        end
    endtask

    initial begin
        logic [15:0] bits;
        reset   = 1'b1;
        seed_in = '0;
        taps_in = '0;
        mode    = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        rounds  = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check("rst_state", 32'(state_out), 32'(SEED));
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_valid", 32'(bit_valid), 32'd0);
        check("rst_bit",   32'(bit_out),   32'd0);
        check("rst_bs",    32'(bitstream), 32'd0);
        check("rst_err",   32'(seed_err),  32'd0);

        // Fibonacci, load and start together, 8 rounds
        seed_in = 4'b1110; taps_in = 4'b0011; mode = 1'b0; rounds = 8'd8;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        check("fib8_busy", 32'(busy), 32'd1);
        bits = 16'b0000_0000_0001_1110;   // 0,1,1,1,1,0,0,0
        run_bits("fib8", 8, bits);
        check("fib8_done",   32'(done),      32'd1);
        check("fib8_vld_off",32'(bit_valid), 32'd0);
        check("fib8_bs",     32'(bitstream), 32'h78);
        check("fib8_state",  32'(state_out), 32'b1001);
        tick();
        check("fib8_idle_done", 32'(done),      32'd0);
        check("fib8_idle_busy", 32'(busy),      32'd0);
        check("fib8_persist",   32'(bitstream), 32'h78);

        // Fibonacci full period with ignored load/start mid-run
        seed_in = 4'b1110; load = 1'b1;
        tick();
        load = 1'b0;
        check("per_load", 32'(state_out), 32'b1110);
        rounds = 8'd15; start = 1'b1;
        tick();
        start = 1'b0;
        bits = 16'b0101_1001_0001_1110;   // 0,1,1,1,1,0,0,0,1,0,0,1,1,0,1
        for (int i = 0; i < 15; i++) begin
            check("per_valid", 32'(bit_valid), 32'd1);
            check("per_bit",   32'(bit_out),   32'(bits[i]));
            if (i == 5) begin
                load = 1'b1; start = 1'b1; seed_in = 4'b0000; rounds = 8'd2;
            end else begin
                load = 1'b0; start = 1'b0;
            end
            tick();
        end
        load = 1'b0; start = 1'b0;
        check("per_done",  32'(done),      32'd1);
        check("per_state", 32'(state_out), 32'b1110);
        check("per_bs",    32'(bitstream), 32'h4D);
        check("per_err",   32'(seed_err),  32'd0);
        tick();

        // Galois, 6 rounds
        seed_in = 4'b0001; taps_in = 4'b1100; mode = 1'b1; rounds = 8'd6;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        bits = 16'b0000_0000_0001_1001;   // 1,0,0,1,1,0
        run_bits("gal6", 6, bits);
        check("gal6_done",  32'(done),      32'd1);
        check("gal6_bs",    32'(bitstream), 32'h26);
        check("gal6_state", 32'(state_out), 32'b0101);
        tick();

        // continue without load: 2 more Galois rounds
        rounds = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        bits = 16'b0000_0000_0000_0001;   // 1,0
        run_bits("cont", 2, bits);
        check("cont_done",  32'(done),      32'd1);
        check("cont_bs",    32'(bitstream), 32'h02);
        check("cont_state", 32'(state_out), 32'b0111);
        tick();

        // zero seed
        seed_in = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        check("zs_state", 32'(state_out), 32'd1);
        check("zs_err",   32'(seed_err),  32'd1);
        tick();
        check("zs_sticky", 32'(seed_err), 32'd1);
        seed_in = 4'b0011; load = 1'b1;
        tick();
        load = 1'b0;
        check("zs_clear", 32'(seed_err),  32'd0);
        check("zs_state2",32'(state_out), 32'b0011);

        // zero rounds
        rounds = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r0_valid", 32'(bit_valid), 32'd0);
        check("r0_done",  32'(done),      32'd1);
        check("r0_busy",  32'(busy),      32'd1);
        check("r0_bs",    32'(bitstream), 32'd0);
        check("r0_state", 32'(state_out), 32'b0011);
        tick();
        check("r0_idle_done", 32'(done), 32'd0);
        check("r0_idle_busy", 32'(busy), 32'd0);

        // reset mid-run at the 3rd bit
        seed_in = 4'b1110; taps_in = 4'b0011; mode = 1'b0; rounds = 8'd8;
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        tick();
        tick();
        check("mr_valid3", 32'(bit_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_state", 32'(state_out), 32'(SEED));
        check("mr_valid", 32'(bit_valid), 32'd0);
        check("mr_bit",   32'(bit_out),   32'd0);
        check("mr_done",  32'(done),      32'd0);
        check("mr_busy",  32'(busy),      32'd0);
        check("mr_bs",    32'(bitstream), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_done",  32'(done),      32'd0);
            check("mr_no_valid", 32'(bit_valid), 32'd0);
        end

        // taps restored to the reset mask: one Galois round from SEED
        mode = 1'b1; rounds = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("rt_bit", 32'(bit_out), 32'd1);
        tick();
        check("rt_done",  32'(done),      32'd1);
        check("rt_state", 32'(state_out), 32'b1100);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lfsr_keystream_gen.md
LFSR_KEYSTREAM_GEN -- requirements
Module: lfsr_keystream_gen

Interface
REQ-001 Parameter WIDTH, 16, LFSR state width; legal range 2..32.
REQ-002 Parameter CNT_W, 8, round-counter width.
REQ-003 Parameter OUT_W, 32, packed bitstream capture width; OUT_W >= 2.
REQ-004 Parameter SEED, 16'hACE1 (WIDTH bits), reset state value; nonzero.
REQ-005 Parameter TAPS, 16'hB400 (WIDTH bits), reset tap mask.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 seed_in  in  WIDTH  seed captured on load.
REQ-009 taps_in  in  WIDTH  feedback tap mask captured on load.
REQ-010 mode  in  1  0 = Fibonacci, 1 = Galois; sampled on accepted start.
REQ-011 load  in  1  capture seed_in/taps_in (accepted in IDLE only).
REQ-012 start  in  1  begin run (accepted in IDLE only).
REQ-013 rounds  in  CNT_W  number of keystream bits to produce; sampled on accepted start.
REQ-014 busy  out  1  high in RUN and DONE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 bit_out / bit_valid  out  1 / 1  keystream bit and its qualifier.
REQ-017 bitstream  out  OUT_W  packed bits; most recent bit at LSB.
REQ-018 state_out  out  WIDTH  current LFSR state.
REQ-019 seed_err  out  1  sticky flag: last load carried an all-zero seed.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start with rounds != 0; IDLE->DONE on accepted start with rounds == 0; RUN->DONE after last bit; DONE->IDLE unconditionally.
REQ-021 Load in IDLE: state <= seed_in, tap register <= taps_in, seed_err <= 0; if seed_in == 0, state <= 1 and seed_err <= 1.
REQ-022 Load and start in the same IDLE cycle: load applies first; run starts from the newly loaded seed and taps.
REQ-023 Load/start outside IDLE: ignored, no state change.
REQ-024 Accepted start: bitstream <= 0, counter <= rounds, mode latched for the run.
REQ-025 Each RUN edge: bit_out <= state[0], bit_valid <= 1, bitstream <= {bitstream[OUT_W-2:0], state[0]}, counter decrements.
REQ-026 Fibonacci next state: {^(state & taps), state[WIDTH-1:1]}.
REQ-027 Galois next state: {1'b0, state[WIDTH-1:1]} XOR (state[0] ? taps : 0).
REQ-028 bit_valid is high for exactly `rounds` consecutive cycles, starting the cycle after the start edge; otherwise 0.
REQ-029 done pulses in the cycle immediately after the last bit_valid cycle (rounds == 0: the cycle after the start edge, no bit_valid).
REQ-030 State, taps and bitstream persist after DONE; a later start without load continues the sequence.
REQ-031 bitstream beyond OUT_W bits keeps only the last OUT_W bits; counter never wraps.

Reset
REQ-032 On reset, state = SEED, taps = TAPS, FSM = IDLE, counter = 0, and bit_out, bit_valid, done, busy, seed_err and bitstream all = 0.
REQ-033 Reset mid-run aborts immediately: no done pulse, no further bit_valid.

Verification
REQ-034 WIDTH=4, OUT_W=8, load seed 4'b1110 taps 4'b0011, mode 0, start rounds 8 -> bits 0,1,1,1,1,0,0,0; bitstream 8'h78; final state 4'b1001; done one cycle later.
REQ-035 Same config, rounds 15 from 4'b1110 -> state returns to 4'b1110 (period 15, maximal).
REQ-036 WIDTH=4, OUT_W=8, seed 4'b0001 taps 4'b1100, mode 1, rounds 6 -> bits 1,0,0,1,1,0; bitstream 8'h26; final state 4'b0101.
REQ-037 Load seed 0 -> state_out 1, seed_err 1; next load with nonzero seed -> seed_err 0.
REQ-038 Start rounds 0 -> no bit_valid, done high the cycle after the start edge; start/load pulsed during RUN -> ignored.
REQ-039 Reset asserted at the 3rd bit of an 8-round run -> all outputs at reset values the next cycle, state_out = SEED, no done pulse.
